// File: rtl/mod_shiftrows_stream_pkg.sv
// mod_shiftrows_stream_pkg: shared AES byte type, default geometry and ShiftRows mode enum
package aes_pkg;
  localparam int DEF_BYTE_W = 8;
  localparam int DEF_NCOLS = 4;
  typedef logic [DEF_BYTE_W-1:0] byte_t;
  typedef enum logic {SR_FWD, SR_INV} sr_mode_e;
endpackage

// File: rtl/mod_shiftrows_stream_if.sv
// mod_shiftrows_stream_if: byte-in / block-out streaming handshake bundle
interface mod_shiftrows_stream_if
  import aes_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int NCOLS = DEF_NCOLS
);
  localparam int NB = 4 * NCOLS;
  logic in_valid;
  logic in_ready;
  logic [BYTE_W-1:0] in_data;
  logic in_last;
  logic in_inv;
  logic out_valid;
  logic out_ready;
  logic [NB*BYTE_W-1:0] out_data;
  logic out_inv;
  modport master(
    output in_valid, in_data, in_last, in_inv, out_ready,
    input in_ready, out_valid, out_data, out_inv
  );
  modport slave(
    input in_valid, in_data, in_last, in_inv, out_ready,
    output in_ready, out_valid, out_data, out_inv
  );
endinterface

// File: rtl/mod_shiftrows_stream_perm.sv
// mod_shiftrows_perm: combinational ShiftRows / InvShiftRows on a row-major 4 x NCOLS state
module mod_shiftrows_perm
  import aes_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int NCOLS = DEF_NCOLS
) (
  input  logic [4*NCOLS*BYTE_W-1:0] state,
  input  sr_mode_e                  mode,
  output logic [4*NCOLS*BYTE_W-1:0] permuted
);
  for (genvar r = 0; r < 4; r++) begin : g_r
    for (genvar c = 0; c < NCOLS; c++) begin : g_c
      localparam int FS = r * NCOLS + (c + r) % NCOLS;
      localparam int IS = r * NCOLS + (c + NCOLS - r % NCOLS) % NCOLS;
      assign permuted[(r*NCOLS+c)*BYTE_W +: BYTE_W] = mode == SR_INV ?
        state[IS*BYTE_W +: BYTE_W] : state[FS*BYTE_W +: BYTE_W];
    end
  end
endmodule

// File: rtl/mod_shiftrows_stream.sv
// mod_shiftrows_stream: ping-pong byte collector presenting ShiftRows-permuted blocks
module mod_shiftrows_stream
  import aes_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int NCOLS = DEF_NCOLS
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clr,
  mod_shiftrows_stream_if.slave   s,
  output logic                    err
);
  localparam int NB = 4 * NCOLS;
  localparam int CW = $clog2(NB);
  logic [NB*BYTE_W-1:0] r_bank [2];
  sr_mode_e             r_mode [2];
  logic [1:0]           r_full;
  logic                 r_wp;
  logic                 r_rp;
  logic [CW-1:0]        r_cnt;
  logic                 r_err;
  logic                 w_acc;
  logic                 w_pop;
  logic                 w_end;
  logic [NB*BYTE_W-1:0] w_perm;
  assign w_acc = s.in_valid && s.in_ready;
  assign w_pop = s.out_valid && s.out_ready;
  assign w_end = r_cnt == CW'(NB - 1);
  assign s.in_ready = ~&r_full;
  assign s.out_valid = r_full[r_rp];
  assign s.out_data = s.out_valid ? w_perm : '0;
  assign s.out_inv = s.out_valid && r_mode[r_rp] == SR_INV;
  assign err = r_err;
  mod_shiftrows_perm #(.BYTE_W(BYTE_W), .NCOLS(NCOLS)) u_perm (
    .state(r_bank[r_rp]),
    .mode(r_mode[r_rp]),
    .permuted(w_perm)
  );
  // The write bank is never the presented bank while filling, so pop and completion never collide
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bank <= '{default: '0};
      r_mode <= '{default: SR_FWD};
      r_full <= '0;
      r_wp <= 1'b0;
      r_rp <= 1'b0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (clr) begin
      r_full <= '0;
      r_wp <= 1'b0;
      r_rp <= 1'b0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_acc && (w_end ? !s.in_last : s.in_last);
      if (w_pop) begin
        r_full[r_rp] <= 1'b0;
        r_rp <= ~r_rp;
      end
      if (w_acc) begin
        r_bank[r_wp][r_cnt*BYTE_W +: BYTE_W] <= s.in_data;
        if (r_cnt == '0) r_mode[r_wp] <= sr_mode_e'(s.in_inv);
        r_cnt <= (w_end || s.in_last) ? '0 : r_cnt + 1'b1;
        if (w_end) begin
          r_full[r_wp] <= 1'b1;
          r_wp <= ~r_wp;
        end
      end
    end
  end
endmodule

// File: tb/tb_mod_shiftrows_stream.sv
// tb_mod_shiftrows_stream: scoreboard bench for the streaming ShiftRows block (NCOLS 4 and 8)
module tb_mod_shiftrows_stream;
  import aes_pkg::*;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic clr = 1'b0;
  logic err_a;
  logic err_b;
  int n_chk = 0;
  int n_err = 0;
  logic [128:0] qa[$];
  logic [256:0] qb[$];
  byte_t fwd4[16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07, 8'h04,
                      8'h0A, 8'h0B, 8'h08, 8'h09, 8'h0F, 8'h0C, 8'h0D, 8'h0E};
  byte_t inv4[16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h04, 8'h05, 8'h06,
                      8'h0A, 8'h0B, 8'h08, 8'h09, 8'h0D, 8'h0E, 8'h0F, 8'h0C};
  byte_t fwd8[32] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                      8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h08,
                      8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h10, 8'h11,
                      8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F, 8'h18, 8'h19, 8'h1A};
  always #5 clk = ~clk;
  mod_shiftrows_stream_if #(.BYTE_W(8), .NCOLS(4)) a ();
  mod_shiftrows_stream_if #(.BYTE_W(8), .NCOLS(8)) b ();
  mod_shiftrows_stream #(.BYTE_W(8), .NCOLS(4)) dut_a (
    .clk(clk), .resetn(resetn), .clr(clr), .s(a.slave), .err(err_a)
  );
  mod_shiftrows_stream #(.BYTE_W(8), .NCOLS(8)) dut_b (
    .clk(clk), .resetn(resetn), .clr(clr), .s(b.slave), .err(err_b)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [128:0] exp_a(input byte_t base, input bit inv);
    logic [128:0] e;
    for (int k = 0; k < 16; k++) e[k*8 +: 8] = byte_t'(base + (inv ? inv4[k] : fwd4[k]));
    e[128] = inv;
    return e;
  endfunction

  always @(negedge clk) begin
    if (a.out_valid && a.out_ready) begin
      if (qa.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL a_unexpected_block got %0h want none", a.out_data);
      end else begin
        logic [128:0] e;
        e = qa.pop_front();
        chk("a_out_data", a.out_data, e[127:0]);
        chk("a_out_inv", a.out_inv, e[128]);
      end
    end
  end

  always @(negedge clk) begin
    if (b.out_valid && b.out_ready) begin
      if (qb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL b_unexpected_block got %0h want none", b.out_data);
      end else begin
        logic [256:0] e;
        e = qb.pop_front();
        chk("b_out_data", b.out_data, e[255:0]);
        chk("b_out_inv", b.out_inv, e[256]);
      end
    end
  end

  // All drivers run at posedge+2 so the negedge monitors never race them
  task automatic send(input bit sel, input byte_t d, input bit last, input bit inv);
    int t = 0;
    if (sel) begin
      b.in_valid = 1'b1; b.in_data = d; b.in_last = last; b.in_inv = inv;
    end else begin
      a.in_valid = 1'b1; a.in_data = d; a.in_last = last; a.in_inv = inv;
    end
    while (!(sel ? b.in_ready : a.in_ready) && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    if (t == 100) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout got in_ready=0 want 1 byte=%0h", d);
    end
    @(posedge clk); #2;
    if (sel) b.in_valid = 1'b0; else a.in_valid = 1'b0;
  endtask

  task automatic block(input bit sel, input byte_t base, input bit inv);
    if (sel) begin
      logic [256:0] e;
      for (int k = 0; k < 32; k++) e[k*8 +: 8] = byte_t'(base + fwd8[k]);
      e[256] = 1'b0;
      qb.push_back(e);
      for (int k = 0; k < 32; k++) send(1'b1, byte_t'(base + k), k == 31, 1'b0);
    end else begin
      qa.push_back(exp_a(base, inv));
      for (int k = 0; k < 16; k++) send(1'b0, byte_t'(base + k), k == 15, inv);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
  endtask

  initial begin
    logic [128:0] e1;
    longint t0;
    a.in_valid = 0; a.in_data = 0; a.in_last = 0; a.in_inv = 0; a.out_ready = 1;
    b.in_valid = 0; b.in_data = 0; b.in_last = 0; b.in_inv = 0; b.out_ready = 1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_err", err_a, 0);
    chk("rst_out_inv", a.out_inv, 0);
    chk("rst_out_data", a.out_data, 0);
    resetn = 1'b1;
    @(posedge clk); #2;
    chk("rst_in_ready_a", a.in_ready, 1);
    chk("rst_in_ready_b", b.in_ready, 1);
    qa.push_back(exp_a(8'h00, 1'b0));
    for (int k = 0; k < 15; k++) send(1'b0, byte_t'(k), 1'b0, 1'b0);
    chk("fwd_pre_valid", a.out_valid, 0);
    send(1'b0, 8'h0F, 1'b1, 1'b0);
    chk("fwd_latency_valid", a.out_valid, 1);
    chk("fwd_no_err", err_a, 0);
    drain();
    block(1'b0, 8'h00, 1'b1);
    drain();
    t0 = $time;
    block(1'b0, 8'h80, 1'b0);
    block(1'b0, 8'h90, 1'b1);
    chk("sustained_rate", 256'($time - t0), 320);
    drain();
    a.out_ready = 1'b0;
    e1 = exp_a(8'h20, 1'b0);
    block(1'b0, 8'h20, 1'b0);
    block(1'b0, 8'h40, 1'b1);
    chk("bp_in_ready_low", a.in_ready, 0);
    chk("bp_out_valid", a.out_valid, 1);
    chk("bp_hold_data", a.out_data, e1[127:0]);
    fork
      block(1'b0, 8'h60, 1'b0);
      begin
        repeat (6) @(posedge clk);
        #2;
        chk("bp_still_held", a.out_data, e1[127:0]);
        chk("bp_still_inv", a.out_inv, 0);
        a.out_ready = 1'b1;
      end
    join
    drain();
    for (int k = 0; k < 6; k++) send(1'b0, byte_t'(k), k == 5, 1'b0);
    chk("early_last_err", err_a, 1);
    @(posedge clk); #2;
    chk("early_last_err_pulse", err_a, 0);
    chk("early_last_no_valid", a.out_valid, 0);
    block(1'b0, 8'h10, 1'b0);
    drain();
    qa.push_back(exp_a(8'hA0, 1'b0));
    for (int k = 0; k < 16; k++) send(1'b0, byte_t'(8'hA0 + k), 1'b0, 1'b0);
    chk("no_last_err", err_a, 1);
    chk("no_last_completes", a.out_valid, 1);
    drain();
    a.out_ready = 1'b0;
    for (int k = 0; k < 26; k++) send(1'b0, byte_t'(k), k == 15, 1'b0);
    chk("clr_pre_valid", a.out_valid, 1);
    clr = 1'b1;
    @(posedge clk); #2;
    clr = 1'b0;
    chk("clr_out_valid", a.out_valid, 0);
    chk("clr_no_err", err_a, 0);
    chk("clr_in_ready", a.in_ready, 1);
    a.out_ready = 1'b1;
    block(1'b0, 8'h30, 1'b0);
    drain();
    a.out_ready = 1'b0;
    for (int k = 0; k < 26; k++) send(1'b0, byte_t'(k), k == 15, 1'b1);
    chk("rst_mid_pre_valid", a.out_valid, 1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_async_valid", a.out_valid, 0);
    chk("rst_mid_async_data", a.out_data, 0);
    @(posedge clk); #2;
    resetn = 1'b1;
    a.out_ready = 1'b1;
    block(1'b0, 8'h50, 1'b1);
    drain();
    block(1'b1, 8'h00, 1'b0);
    drain();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
